// File: rtl/corepcie_axi_reg_target.sv
// AXI3 single-beat slave bridging onto the PCIe local register req/ack bus.
// One transaction in flight; bursts are drained and answered with SLVERR.
module corepcie_axi_reg_target #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic [3:0]  AWLEN,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    input  logic [3:0]  ARLEN,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        REG_REQ,
    output logic        REG_WE,
    output logic [28:0] REG_ADDR,
    output logic [63:0] REG_WDATA,
    output logic [7:0]  REG_BE,
    input  logic        REG_ACK,
    input  logic [63:0] REG_RDATA,
    input  logic        REG_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_REQ,
        S_BRSP,
        S_RDRAIN,
        S_RRSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_e      state_q, state_d;
    logic        prio_w_q, prio_w_d;
    logic        we_q, we_d;
    logic [28:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        req_q, req_d;
    logic [31:0] to_cnt_q, to_cnt_d;

    logic aw_go;
    logic ar_go;
    logic to_hit;

    // Word-aligned bus: low address bits and WLAST carry no information here.
    logic unused_bits;
    assign unused_bits = ^{AWADDR[2:0], ARADDR[2:0], WLAST};

    assign aw_go = (state_q == S_IDLE) && AWVALID && (!ARVALID || prio_w_q);
    assign ar_go = (state_q == S_IDLE) && ARVALID && (!AWVALID || !prio_w_q);

    assign to_hit = (TIMEOUT_CYC != 0) && (to_cnt_q == TIMEOUT_CYC - 32'd1);

    assign AWREADY   = aw_go;
    assign ARREADY   = ar_go;
    assign BRESP     = resp_q;
    assign RRESP     = resp_q;
    assign RDATA     = rdata_q;
    assign REG_REQ   = req_q;
    assign REG_WE    = we_q;
    assign REG_ADDR  = addr_q;
    assign REG_WDATA = wdata_q;
    assign REG_BE    = be_q;

    // State and payload registers, cleared by synchronous reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q  <= S_IDLE;
            prio_w_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            resp_q   <= RESP_OKAY;
            req_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_w_q <= prio_w_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
            req_q    <= req_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next-state, payload updates and channel outputs.
    always_comb begin
        state_d  = state_q;
        prio_w_d = prio_w_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
        req_d    = req_q;
        to_cnt_d = to_cnt_q;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        RVALID   = 1'b0;
        RLAST    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (aw_go) begin
                    addr_d   = AWADDR[31:3];
                    len_d    = AWLEN;
                    cnt_d    = AWLEN;
                    we_d     = 1'b1;
                    prio_w_d = 1'b0;
                    resp_d   = RESP_OKAY;
                    state_d  = S_WDATA;
                end else if (ar_go) begin
                    addr_d   = ARADDR[31:3];
                    len_d    = ARLEN;
                    cnt_d    = ARLEN;
                    we_d     = 1'b0;
                    be_d     = 8'hFF;
                    prio_w_d = 1'b1;
                    rdata_d  = '0;
                    if (ARLEN == 4'd0) begin
                        resp_d  = RESP_OKAY;
                        state_d = S_REQ;
                    end else begin
                        resp_d  = RESP_SLVERR;
                        state_d = S_RDRAIN;
                    end
                end
            end
            S_WDATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    wdata_d = WDATA;
                    be_d    = WSTRB;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (len_q == 4'd0) begin
                        state_d = S_REQ;
                    end else begin
                        resp_d  = RESP_SLVERR;
                        state_d = S_BRSP;
                    end
                end
            end
            S_REQ: begin
                if (!req_q) begin
                    req_d    = 1'b1;
                    to_cnt_d = '0;
                end else if (REG_ACK) begin
                    req_d   = 1'b0;
                    resp_d  = REG_ERR ? RESP_SLVERR : RESP_OKAY;
                    if (!we_q) begin
                        rdata_d = REG_RDATA;
                    end
                    state_d = we_q ? S_BRSP : S_RRSP;
                end else if (to_hit) begin
                    req_d   = 1'b0;
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    state_d = we_q ? S_BRSP : S_RRSP;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            S_BRSP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    state_d = S_IDLE;
                end
            end
            S_RDRAIN: begin
                RVALID = 1'b1;
                RLAST  = (cnt_q == 4'd0);
                if (RREADY) begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_RRSP: begin
                RVALID = 1'b1;
                RLAST  = 1'b1;
                if (RREADY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
